// File: rtl/gpio_pkg.sv
// Shared GPIO input types and defaults.
// Imported by gpio_debounce and gpio_in.
package gpio_pkg;

  localparam int NUM_BITS_DEF        = 8;
  localparam int DEBOUNCE_CYCLES_DEF = 16;

  typedef logic [NUM_BITS_DEF-1:0] gpio_vec_t;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One input bit: 2-flop synchroniser, stability counter, clean level.
// o_edge pulses combinationally on the cycle the level is about to flip.
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_edge,
  output logic o_rise
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  logic w_diff;
  logic w_done;

  assign w_diff = r_s2 ^ r_level;
  assign w_done = w_diff && (r_cnt == CNT_MAX);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1 <= i_pin;
      r_s2 <= r_s1;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_level <= r_s2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_edge  = w_done;
  assign o_rise  = w_done & r_s2;

endmodule

// File: rtl/gpio_in.sv
// Debounced GPIO inputs with sticky rise/fall/overrun flags.
// Optional registered interrupt when GPIO_IN_IRQ_EN is defined.
module gpio_in
  import gpio_pkg::*;
#(
  parameter int NUM_BITS        = NUM_BITS_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BITS-1:0] gpio_i,
  input  logic                clr_i,
  input  logic [NUM_BITS-1:0] clr_mask,
`ifdef GPIO_IN_IRQ_EN
  input  logic [NUM_BITS-1:0] irq_mask,
  output logic                irq_o,
`endif
  output logic [NUM_BITS-1:0] level_o,
  output logic [NUM_BITS-1:0] rise_o,
  output logic [NUM_BITS-1:0] fall_o,
  output logic [NUM_BITS-1:0] ovr_o
);

  logic [NUM_BITS-1:0] w_level;
  logic [NUM_BITS-1:0] w_edge;
  logic [NUM_BITS-1:0] w_rise_set;
  logic [NUM_BITS-1:0] w_fall_set;
  logic [NUM_BITS-1:0] w_clr;
  logic [NUM_BITS-1:0] w_pend;
  logic [NUM_BITS-1:0] w_rise_nxt;
  logic [NUM_BITS-1:0] w_fall_nxt;
  logic [NUM_BITS-1:0] w_ovr_nxt;

  logic [NUM_BITS-1:0] r_rise;
  logic [NUM_BITS-1:0] r_fall;
  logic [NUM_BITS-1:0] r_ovr;

  for (genvar g = 0; g < NUM_BITS; g++) begin : g_bit
    gpio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_pin  (gpio_i[g]),
      .o_level(w_level[g]),
      .o_edge (w_edge[g]),
      .o_rise (w_rise_set[g])
    );
  end

  // Set beats clear; a cleared bit also drops any overrun from this edge.
  always_comb begin
    w_fall_set = w_edge & ~w_rise_set;
    w_clr      = {NUM_BITS{clr_i}} & clr_mask;
    w_pend     = r_rise | r_fall;
    w_rise_nxt = (r_rise & ~w_clr) | w_rise_set;
    w_fall_nxt = (r_fall & ~w_clr) | w_fall_set;
    w_ovr_nxt  = (r_ovr | (w_edge & w_pend)) & ~w_clr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rise <= '0;
      r_fall <= '0;
      r_ovr  <= '0;
    end else begin
      r_rise <= w_rise_nxt;
      r_fall <= w_fall_nxt;
      r_ovr  <= w_ovr_nxt;
    end
  end

`ifdef GPIO_IN_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(w_pend & irq_mask);
    end
  end

  assign irq_o = r_irq;
`endif

  assign level_o = w_level;
  assign rise_o  = r_rise;
  assign fall_o  = r_fall;
  assign ovr_o   = r_ovr;

endmodule
